// File: rtl/pipe_pkg.sv
// Shared types and default widths for the pipeline stage buffer.
// The state enum encodes how many of the two entries (main, skid) hold a beat.
package pipe_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int CTRL_W_DEF = 8;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: steps by one on inc, sticks at all-ones, cleared only by rst.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Two-entry skid buffer between pipeline stages: registered in_ready, control
// bits zeroed on flush/bubble, and a saturating count of upstream stall cycles.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    state_e            state_q;
    logic              in_ready_q;
    logic [DATA_W-1:0] main_data_q, skid_data_q;
    logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;

    logic accept, pop;

    assign accept = in_valid && in_ready_q;
    assign pop    = (state_q != EMPTY) && out_ready;

    // Entries are cleared whenever they go invalid, so main can drive out_*
    // directly and an idle stage presents an all-zero NOP.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_q     <= ONE;
                        main_data_q <= in_data;
                        main_ctrl_q <= in_ctrl;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        main_data_q <= in_data;
                        main_ctrl_q <= in_ctrl;
                    end else if (accept) begin
                        state_q     <= FULL;
                        in_ready_q  <= 1'b0;
                        skid_data_q <= in_data;
                        skid_ctrl_q <= in_ctrl;
                    end else if (pop) begin
                        state_q     <= EMPTY;
                        main_data_q <= '0;
                        main_ctrl_q <= '0;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_q     <= ONE;
                        in_ready_q  <= 1'b1;
                        main_data_q <= skid_data_q;
                        main_ctrl_q <= skid_ctrl_q;
                        skid_data_q <= '0;
                        skid_ctrl_q <= '0;
                    end
                end
                default: begin
                    state_q    <= EMPTY;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_data_q;
    assign out_ctrl  = main_ctrl_q;

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk(clk),
        .rst(rst),
        .inc(in_valid && !in_ready_q && !flush),
        .cnt(stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: directed scenarios plus random traffic, all
// checked against a queue-based model of the stage.
module tb_pipe_stage_buf;

    localparam int DW  = 32;
    localparam int CW  = 8;
    localparam int NW  = 4;
    localparam int MAX = (1 << NW) - 1;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, out_ready;
    logic          in_ready, out_valid;
    logic [DW-1:0] in_data, out_data;
    logic [CW-1:0] in_ctrl, out_ctrl;
    logic [NW-1:0] stall_cnt;

    pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ctrl(out_ctrl),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // model: queue of held beats {ctrl,data}, capacity 2, plus stall count
    logic [CW+DW-1:0] mq[$];
    int               mcnt = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [CW+DW-1:0] hd;
        hd = (mq.size() > 0) ? mq[0] : '0;
        chk({tag, ".ovld"}, 32'(out_valid), 32'(mq.size() > 0));
        chk({tag, ".irdy"}, 32'(in_ready), 32'(mq.size() < 2));
        chk({tag, ".odat"}, out_data, hd[DW-1:0]);
        chk({tag, ".octl"}, 32'(out_ctrl), 32'(hd[CW+DW-1:DW]));
        chk({tag, ".scnt"}, 32'(stall_cnt), 32'(mcnt));
    endtask

    // Drive one cycle of inputs, advance the model at the edge, check at negedge.
    task automatic step(input string tag, input logic r, input logic f, input logic iv,
                        input logic [DW-1:0] id, input logic [CW-1:0] ic, input logic ordy);
        bit rdy, acc, pp;
        rst = r; flush = f; in_valid = iv; in_data = id; in_ctrl = ic; out_ready = ordy;
        @(posedge clk);
        rdy = (mq.size() < 2);
        acc = iv && rdy;
        pp  = (mq.size() > 0) && ordy;
        if (r) begin
            mq.delete();
            mcnt = 0;
        end else begin
            if (iv && !rdy && !f && mcnt < MAX) mcnt++;
            if (f) mq.delete();
            else begin
                if (pp) void'(mq.pop_front());
                if (acc) mq.push_back({ic, id});
            end
        end
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0;
        @(negedge clk);

        // reset then idle
        step("rst", 1, 0, 0, 0, 0, 0);
        step("idle", 0, 0, 0, 0, 0, 0);
        chk("idle.cnt0", 32'(stall_cnt), 0);

        // streaming with no bubbles
        step("s10", 0, 0, 1, 32'h10, 8'h01, 1);
        chk("s10.out", out_data, 32'h10);
        step("s14", 0, 0, 1, 32'h14, 8'h02, 1);
        chk("s14.out", out_data, 32'h14);
        step("s18", 0, 0, 1, 32'h18, 8'h03, 1);
        chk("s18.out", out_data, 32'h18);
        step("sdrain", 0, 0, 0, 0, 0, 1);

        // fill, stall three cycles, drain in order
        step("rst2", 1, 0, 0, 0, 0, 0);
        step("pA", 0, 0, 1, 32'hA, 8'h11, 0);
        step("pB", 0, 0, 1, 32'hB, 8'h22, 0);
        chk("full.irdy", 32'(in_ready), 0);
        for (int i = 0; i < 3; i++) step("hold", 0, 0, 1, 32'hC, 8'h33, 0);
        chk("stall3", 32'(stall_cnt), 3);
        step("dA", 0, 0, 0, 0, 0, 1);
        chk("dA.out", out_data, 32'hB);
        step("dB", 0, 0, 0, 0, 0, 1);
        chk("dB.vld", 32'(out_valid), 0);

        // flush while full with an incoming beat
        step("fA", 0, 0, 1, 32'h21, 8'hFF, 0);
        step("fB", 0, 0, 1, 32'h22, 8'hFF, 0);
        step("flush", 0, 1, 1, 32'h23, 8'hFF, 0);
        chk("flush.vld", 32'(out_valid), 0);
        chk("flush.ctl", 32'(out_ctrl), 0);
        chk("flush.rdy", 32'(in_ready), 1);
        step("flush2", 0, 0, 0, 0, 0, 0);

        // saturation after long backpressure
        step("rst3", 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 22; i++) step("bp", 0, 0, 1, 32'(i), 8'(i), 0);
        chk("sat15", 32'(stall_cnt), 15);

        // reset and flush together while full
        step("rstfl", 1, 1, 1, 32'h55, 8'h55, 1);
        chk("rstfl.cnt", 32'(stall_cnt), 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step("rnd",
                 ($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 9) < 7),
                 $urandom(), 8'($urandom()),
                 ($urandom_range(0, 9) < 6));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1);
    end

endmodule
